// File: rtl/dense_pkg.sv
// Shared definitions for the skewed matrix feeder: default sizes, FSM states
// and the lane-count helper.
package dense_pkg;

  localparam int N_DEFAULT          = 4;
  localparam int DATA_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  // A skewed row of N elements spans 2N-1 output lanes.
  function automatic int lane_count(input int n);
    return 2 * n - 1;
  endfunction

  localparam int LANES_DEFAULT = lane_count(N_DEFAULT);

endpackage

// File: rtl/dense_mat_buf.sv
// N x N register file with one write port and a combinational whole-row read.
module dense_mat_buf
  import dense_pkg::*;
#(
  parameter int N          = N_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [$clog2(N)-1:0]    wr_row,
  input  logic [$clog2(N)-1:0]    wr_col,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [$clog2(N)-1:0]    rd_row,
  output logic [DATA_WIDTH-1:0]   rd_data [0:N-1]
);

  logic [DATA_WIDTH-1:0] mem [0:N-1][0:N-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          mem[r][c] <= '0;
        end
      end
    end else if (wr_en) begin
      mem[wr_row][wr_col] <= wr_data;
    end
  end

  always_comb begin
    for (int c = 0; c < N; c++) begin
      rd_data[c] = mem[rd_row][c];
    end
  end

endmodule

// File: rtl/dense_skew_feeder.sv
// Streams matrices A and B row by row onto 2N-1 skewed lanes (row t shifted
// right by t lanes), one registered beat per cycle, followed by a FLUSH cycle.
module dense_skew_feeder
  import dense_pkg::*;
#(
  parameter int N          = N_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [$clog2(N)-1:0]  wr_row,
  input  logic [$clog2(N)-1:0]  wr_col,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_err,
  output logic [DATA_WIDTH-1:0] a_in_bus       [0:2*N-2],
  output logic                  valid_bit_a_in [0:2*N-2],
  output logic [DATA_WIDTH-1:0] b_in_bus       [0:2*N-2],
  output logic                  valid_bit_b_in [0:2*N-2]
);

  localparam int IW    = $clog2(N);
  localparam int TW    = $clog2(N) + 1;
  localparam int LANES = lane_count(N);

  state_t                state, state_next;
  logic [TW-1:0]         t, t_next;
  logic [TW-1:0]         beat;
  logic                  load;
  logic                  accept_wr;
  logic                  err_q;
  logic [IW-1:0]         rd_row;
  logic [DATA_WIDTH-1:0] a_row [0:N-1];
  logic [DATA_WIDTH-1:0] b_row [0:N-1];
  logic [DATA_WIDTH-1:0] a_fwd [0:N-1];
  logic [DATA_WIDTH-1:0] b_fwd [0:N-1];
  logic [DATA_WIDTH-1:0] a_next [0:LANES-1];
  logic [DATA_WIDTH-1:0] b_next [0:LANES-1];

  assign accept_wr = wr_en && (state == IDLE);
  assign rd_row    = beat[IW-1:0];

  dense_mat_buf #(.N(N), .DATA_WIDTH(DATA_WIDTH)) u_mat_a (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept_wr && !wr_sel),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .rd_row  (rd_row),
    .rd_data (a_row)
  );

  dense_mat_buf #(.N(N), .DATA_WIDTH(DATA_WIDTH)) u_mat_b (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept_wr && wr_sel),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .rd_row  (rd_row),
    .rd_data (b_row)
  );

  // Outputs hold beat t; beat is the row being registered on the coming edge.
  always_comb begin
    state_next = state;
    t_next     = t;
    load       = 1'b0;
    beat       = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = STREAM;
          t_next     = '0;
          load       = 1'b1;
        end
      end
      STREAM: begin
        if (t == TW'(N - 1)) begin
          state_next = FLUSH;
          t_next     = '0;
        end else begin
          t_next = t + 1'b1;
          beat   = t + 1'b1;
          load   = 1'b1;
        end
      end
      FLUSH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Beat 0 is registered on the same edge as a same-cycle write, so bypass it.
  always_comb begin
    for (int c = 0; c < N; c++) begin
      a_fwd[c] = a_row[c];
      b_fwd[c] = b_row[c];
    end
    if (accept_wr && (wr_row == rd_row)) begin
      if (wr_sel) b_fwd[wr_col] = wr_data;
      else        a_fwd[wr_col] = wr_data;
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      a_next[k] = '0;
      b_next[k] = '0;
    end
    for (int j = 0; j < N; j++) begin
      a_next[int'(beat) + j] = a_fwd[j];
      b_next[int'(beat) + j] = b_fwd[j];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      t     <= '0;
      err_q <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        a_in_bus[k]       <= '0;
        b_in_bus[k]       <= '0;
        valid_bit_a_in[k] <= 1'b0;
        valid_bit_b_in[k] <= 1'b0;
      end
    end else begin
      state <= state_next;
      t     <= t_next;
      err_q <= wr_en && (state != IDLE);
      for (int k = 0; k < LANES; k++) begin
        a_in_bus[k]       <= load ? a_next[k] : '0;
        b_in_bus[k]       <= load ? b_next[k] : '0;
        valid_bit_a_in[k] <= load;
        valid_bit_b_in[k] <= load;
      end
    end
  end

  assign busy   = (state != IDLE);
  assign done   = (state == FLUSH);
  assign wr_err = err_q;

endmodule

// File: tb/tb_dense_skew_feeder.sv
// Bench for dense_skew_feeder: queue-based reference model checked every cycle,
// a vector table for the counting-matrix stream, and directed corner sequences.
module tb_dense_skew_feeder;
  import dense_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int L  = 2 * N - 1;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic          wr_sel;
  logic [1:0]    wr_row;
  logic [1:0]    wr_col;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          busy;
  logic          done;
  logic          wr_err;
  logic [DW-1:0] a_in_bus       [0:L-1];
  logic          valid_bit_a_in [0:L-1];
  logic [DW-1:0] b_in_bus       [0:L-1];
  logic          valid_bit_b_in [0:L-1];

  dense_skew_feeder #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_sel         (wr_sel),
    .wr_row         (wr_row),
    .wr_col         (wr_col),
    .wr_data        (wr_data),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .wr_err         (wr_err),
    .a_in_bus       (a_in_bus),
    .valid_bit_a_in (valid_bit_a_in),
    .b_in_bus       (b_in_bus),
    .valid_bit_b_in (valid_bit_b_in)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] ma [N][N];
  logic [DW-1:0] mb [N][N];
  logic [7:0]    exp_q[$];   // upcoming displayed phases: 0..N-1 beats, N = flush
  int            cur = -1;   // phase on the outputs now, -1 = idle
  logic          m_err = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = '0;
        mb[r][c] = '0;
      end
    exp_q.delete();
    cur   = -1;
    m_err = 1'b0;
  endtask

  task automatic compare_all();
    logic [DW-1:0] ea, eb;
    logic ev;
    check("busy", int'(busy), int'(cur != -1));
    check("done", int'(done), int'(cur == N));
    check("wr_err", int'(wr_err), int'(m_err));
    for (int k = 0; k < L; k++) begin
      ea = '0; eb = '0; ev = 1'b0;
      if (cur >= 0 && cur < N) begin
        ev = 1'b1;
        if (k >= cur && k - cur < N) begin
          ea = ma[cur][k-cur];
          eb = mb[cur][k-cur];
        end
      end
      check($sformatf("a_lane%0d", k), int'(a_in_bus[k]), int'(ea));
      check($sformatf("b_lane%0d", k), int'(b_in_bus[k]), int'(eb));
      check($sformatf("va_lane%0d", k), int'(valid_bit_a_in[k]), int'(ev));
      check($sformatf("vb_lane%0d", k), int'(valid_bit_b_in[k]), int'(ev));
    end
  endtask

  // Advance the model for the coming edge, clock it, then compare.
  task automatic tick();
    if (rst) begin
      model_clear();
    end else begin
      m_err = wr_en && (cur != -1);
      if (cur == -1) begin
        if (wr_en) begin
          if (wr_sel) mb[wr_row][wr_col] = wr_data;
          else        ma[wr_row][wr_col] = wr_data;
        end
        if (start)
          for (int i = 0; i <= N; i++) exp_q.push_back(8'(i));
      end
      cur = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : -1;
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic sel, input int row, input int col, input int data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_row  = 2'(row);
    wr_col  = 2'(col);
    wr_data = 8'(data);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        busy;
    logic        done;
    logic        valid;
    logic [55:0] a;   // lane 0 in the most significant byte
    logic [55:0] b;
  } vec_t;

  vec_t vecs [6];

  task automatic apply_vec(input int i);
    logic [55:0] va, vb;
    va = vecs[i].a;
    vb = vecs[i].b;
    check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].busy));
    check($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].done));
    for (int k = 0; k < L; k++) begin
      check($sformatf("vec%0d_a%0d", i, k), int'(a_in_bus[k]), int'(va[(6-k)*8 +: 8]));
      check($sformatf("vec%0d_b%0d", i, k), int'(b_in_bus[k]), int'(vb[(6-k)*8 +: 8]));
      check($sformatf("vec%0d_va%0d", i, k), int'(valid_bit_a_in[k]), int'(vecs[i].valid));
      check($sformatf("vec%0d_vb%0d", i, k), int'(valid_bit_b_in[k]), int'(vecs[i].valid));
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int beats;
    int dones;

    vecs[0] = '{busy: 1'b1, done: 1'b0, valid: 1'b1,
                a: {8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0},
                b: {8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[1] = '{busy: 1'b1, done: 1'b0, valid: 1'b1,
                a: {8'd0, 8'd5, 8'd6, 8'd7, 8'd8, 8'd0, 8'd0},
                b: {8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[2] = '{busy: 1'b1, done: 1'b0, valid: 1'b1,
                a: {8'd0, 8'd0, 8'd9, 8'd10, 8'd11, 8'd12, 8'd0},
                b: {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0}};
    vecs[3] = '{busy: 1'b1, done: 1'b0, valid: 1'b1,
                a: {8'd0, 8'd0, 8'd0, 8'd13, 8'd14, 8'd15, 8'd16},
                b: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1}};
    vecs[4] = '{busy: 1'b1, done: 1'b1, valid: 1'b0, a: 56'd0, b: 56'd0};
    vecs[5] = '{busy: 1'b0, done: 1'b0, valid: 1'b0, a: 56'd0, b: 56'd0};

    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0;
    wr_data = '0; start = 1'b0;
    model_clear();
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(2);
    check("reset_busy", int'(busy), 0);
    check("reset_a_lane0", int'(a_in_bus[0]), 0);

    // Counting matrix A, identity B, streamed against the table.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        do_write(1'b0, r, c, r * N + c + 1);
        do_write(1'b1, r, c, (r == c) ? 1 : 0);
      end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      apply_vec(i);
    end

    // Write during STREAM is rejected and flagged.
    start = 1'b1; tick(); start = 1'b0;
    tick();
    wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd2; wr_col = 2'd1; wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    check("stream_wr_err", int'(wr_err), 1);
    tick();
    check("stream_wr_err_single", int'(wr_err), 0);
    idle_cycles(2);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("rejected_write_lane3", int'(a_in_bus[3]), 10);
    idle_cycles(3);

    // Start in the IDLE cycle right after FLUSH.
    start = 1'b1; tick(); start = 1'b0;
    idle_cycles(3);
    tick();
    check("b2b_done", int'(done), 1);
    tick();
    check("b2b_idle", int'(busy), 0);
    start = 1'b1; tick(); start = 1'b0;
    beats = int'(valid_bit_a_in[0]);
    for (int i = 0; i < 3; i++) begin
      tick();
      beats += int'(valid_bit_a_in[0]);
    end
    check("b2b_valid_run", beats, 4);
    idle_cycles(2);

    // Start together with a write to B[0][0].
    wr_en = 1'b1; wr_sel = 1'b1; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'd7;
    start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    check("start_with_write_b0", int'(b_in_bus[0]), 7);
    idle_cycles(5);

    // Repeated start during STREAM is ignored.
    start = 1'b1;
    beats = 0; dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 2) start = 1'b0;
      beats += int'(valid_bit_a_in[0]);
      dones += int'(done);
    end
    check("restart_beats", beats, 4);
    check("restart_dones", dones, 1);

    // Reset asserted mid-beat 2.
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_a_lane2", int'(a_in_bus[2]), 0);
    check("rst_va_lane0", int'(valid_bit_a_in[0]), 0);
    check("rst_b_lane2", int'(b_in_bus[2]), 0);
    tick();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      dones += int'(done);
    end
    check("rst_no_done", dones, 0);
    start = 1'b1; tick(); start = 1'b0;
    check("rst_zero_a0", int'(a_in_bus[0]), 0);
    check("rst_zero_b0", int'(b_in_bus[0]), 0);
    check("rst_valid_beat0", int'(valid_bit_a_in[0]), 1);
    idle_cycles(5);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_sel  = 1'($urandom_range(0, 1));
      wr_row  = 2'($urandom_range(0, N - 1));
      wr_col  = 2'($urandom_range(0, N - 1));
      wr_data = 8'($urandom_range(0, 255));
      start   = ($urandom_range(0, 5) == 0);
      rst     = ($urandom_range(0, 99) == 0);
      tick();
    end
    wr_en = 1'b0; start = 1'b0; rst = 1'b0;
    idle_cycles(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dense_skew_feeder.md
DENSE_SKEW_FEEDER -- requirements
Module: dense_skew_feeder

Interface
REQ-001 SHALL have parameter N, default 4, meaning the matrix dimension (N x N).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning the element width in bits.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-005 SHALL have port wr_en, input, 1 bit, the element write strobe.
REQ-006 SHALL have port wr_sel, input, 1 bit, selecting the target matrix: 0 = A, 1 = B.
REQ-007 SHALL have ports wr_row and wr_col, input, each $clog2(N) bits, giving the element index.
REQ-008 SHALL have port wr_data, input, DATA_WIDTH bits, the element value.
REQ-009 SHALL have port start, input, 1 bit, a single-cycle request to stream.
REQ-010 SHALL have port busy, output, 1 bit, high while streaming.
REQ-011 SHALL have port done, output, 1 bit, a single-cycle pulse when the stream completes.
REQ-012 SHALL have port wr_err, output, 1 bit, a single-cycle pulse when a write is rejected.
REQ-013 SHALL have port a_in_bus, output, unpacked [0:2N-2] of DATA_WIDTH bits, the skewed A lanes to dense_mult.
REQ-014 SHALL have port valid_bit_a_in, output, unpacked [0:2N-2] of 1 bit, the per-lane A valid.
REQ-015 SHALL have ports b_in_bus and valid_bit_b_in, outputs, sized as a_in_bus and valid_bit_a_in, carrying the skewed B lanes.

Function
REQ-016 SHALL hold two N x N register arrays, A and B.
REQ-017 SHALL write wr_data into the selected array at [wr_row][wr_col] on a clock edge with wr_en=1 and state IDLE; the write takes effect on that edge.
REQ-018 SHALL ignore wr_en=1 outside IDLE, leave both arrays unchanged, and pulse wr_err for one cycle on the next edge.
REQ-019 SHALL implement an FSM with states IDLE, STREAM and FLUSH, with beat counter t of width $clog2(N)+1.
REQ-020 SHALL move from IDLE to STREAM with t=0 on an edge where start=1.
REQ-021 SHALL ignore start outside IDLE.
REQ-022 SHALL, when start and wr_en are both high in IDLE, perform the write first so that beat 0 sees the new value.
REQ-023 SHALL, in STREAM beat t, register on the output every lane k (0..2N-2) with a_in_bus[k] = A[t][k-t] when t <= k <= t+N-1, else 0.
REQ-024 SHALL drive b_in_bus identically from B (b_in_bus[k] = B[t][k-t] in window, else 0).
REQ-025 SHALL drive all valid_bit_a_in and valid_bit_b_in lanes to 1 during every STREAM beat, including the zero-padded lanes.
REQ-026 SHALL give a one-cycle output latency: beat t appears on the outputs during the cycle after the edge that registered it; beat 0 appears on the cycle after the start edge.
REQ-027 SHALL stream exactly N consecutive beats with no gaps, t = 0..N-1.
REQ-028 SHALL enter FLUSH after beat N-1; in FLUSH all buses and valids are 0, done=1 for exactly that cycle, and the FSM returns to IDLE on the next edge.
REQ-029 SHALL hold busy=1 from the first beat through the FLUSH cycle inclusive, and busy=0 otherwise.
REQ-030 SHALL hold all buses and valids at 0 in IDLE.
REQ-031 SHALL, on start arriving in the IDLE cycle immediately after FLUSH, begin a new stream with the same one-cycle latency.
REQ-032 SHALL perform no arithmetic; array indices are always in range because the index widths are exactly $clog2(N).

Reset
REQ-033 SHALL, on rst=1 at any time (including mid-STREAM), force the FSM to IDLE, t to 0, busy, done and wr_err to 0, and all bus and valid lanes to 0 immediately, with no partial beat emitted after reset deasserts.
REQ-034 SHALL reset both A and B arrays to all zeros.

Structure
REQ-035 SHALL place defaults for N and DATA_WIDTH, the state enum type, and a lane-count constant (2N-1) in the shared package dense_pkg.
REQ-036 SHALL implement each matrix store as one instance of sub-module dense_mat_buf (N x N register file, one write port, combinational row read), instantiated twice: once for A, once for B.

Verification
REQ-037 SHALL cover: A = 1..16 row-major, B = identity, start -> beats 0..3 show a lanes 0-3 = 1,2,3,4; lanes 1-4 = 5,6,7,8; lanes 2-5 = 9,10,11,12; lanes 3-6 = 13,14,15,16; b lanes 0, 2, 4, 6 = 1 on beats 0..3 respectively; done pulses on the 5th cycle after start.
REQ-038 SHALL cover: wr_en to A[2][1]=0x55 during STREAM -> wr_err pulses, and a second stream shows a lane 3 = the prior value on beat 2.
REQ-039 SHALL cover: rst asserted during beat 2 -> all outputs 0 immediately, busy=0, no done pulse, and arrays read zero on the next stream.
REQ-040 SHALL cover: start issued on the cycle after done -> beat 0 appears one cycle later, valids continuous for 4 cycles.
REQ-041 SHALL cover: start together with a write of B[0][0]=7 in IDLE -> b lane 0 = 7 on beat 0.
REQ-042 SHALL cover: a repeated start during STREAM -> ignored, exactly 4 beats and one done pulse.
